// File: rtl/uart_fifo_wr_ctrl.sv
// uart_fifo_wr_ctrl
//   Write-side controller for an asynchronous UART FIFO. It owns the binary
//   write pointer and its registered Gray copy, brings the Gray read pointer
//   in from the read clock domain through a two-flop synchronizer, and
//   derives full, occupancy level and a sticky overflow flag from them.
//
// Optional feature:
//   UART_FIFO_WR_AFULL_EN  when defined, adds the o_wr_ctrl_afull output
//                          (registered, level >= AF_THRESH).
//
// Ports:
//   i_mem_ctrl_wclk      write clock
//   i_mem_ctrl_wrst_n    asynchronous active-low reset
//   i_wr_ctrl_winc       write request from the producer
//   i_wr_ctrl_wdata      write data
//   i_wr_ctrl_ovf_clr    clears the sticky overflow flag
//   i_wr_ctrl_rptr_gray  Gray read pointer from the read domain (async)
//   o_mem_ctrl_wclk_en   memory write enable (combinational)
//   o_mem_ctrl_waddr     memory write address (combinational)
//   o_mem_ctrl_wdata     memory write data (combinational pass-through)
//   o_wr_ctrl_wptr_gray  registered Gray write pointer to the read domain
//   o_wr_ctrl_full       FIFO full
//   o_wr_ctrl_level      write-side occupancy, 0..FIFO_DEPTH
//   o_wr_ctrl_ovf        sticky overflow (write attempted while full)
//   o_wr_ctrl_afull      almost full (only with UART_FIFO_WR_AFULL_EN)
module uart_fifo_wr_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
    input  logic                 i_mem_ctrl_wclk,
    input  logic                 i_mem_ctrl_wrst_n,
    input  logic                 i_wr_ctrl_winc,
    input  logic [7:0]           i_wr_ctrl_wdata,
    input  logic                 i_wr_ctrl_ovf_clr,
    input  logic [PTR_WIDTH-1:0] i_wr_ctrl_rptr_gray,
    output logic                 o_mem_ctrl_wclk_en,
    output logic [PTR_WIDTH-2:0] o_mem_ctrl_waddr,
    output logic [7:0]           o_mem_ctrl_wdata,
    output logic [PTR_WIDTH-1:0] o_wr_ctrl_wptr_gray,
    output logic                 o_wr_ctrl_full,
    output logic [PTR_WIDTH-1:0] o_wr_ctrl_level,
    output logic                 o_wr_ctrl_ovf
`ifdef UART_FIFO_WR_AFULL_EN
    ,
    output logic                 o_wr_ctrl_afull
`endif
);

    // Full when the next write pointer equals the synchronized read pointer
    // with its two top Gray bits inverted; XOR with this mask does the
    // inversion and also works for the minimum 2-bit pointer.
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

`ifdef UART_FIFO_WR_AFULL_EN
    localparam logic [PTR_WIDTH-1:0] AF_LIMIT = PTR_WIDTH'(AF_THRESH);
`endif

    logic [PTR_WIDTH-1:0] wbin_q,  wbin_d;
    logic [PTR_WIDTH-1:0] wgray_q, wgray_d;
    logic [PTR_WIDTH-1:0] rq1_q,   rq1_d;
    logic [PTR_WIDTH-1:0] rq2_q,   rq2_d;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic                 full_q,  full_d;
    logic                 ovf_q,   ovf_d;
    logic [PTR_WIDTH-1:0] rbin;
    logic                 wclk_en;
`ifdef UART_FIFO_WR_AFULL_EN
    logic                 afull_q, afull_d;
`endif

    always_comb begin
        wclk_en = i_wr_ctrl_winc & ~full_q;
        wbin_d  = wbin_q + {{(PTR_WIDTH-1){1'b0}}, wclk_en};
        wgray_d = (wbin_d >> 1) ^ wbin_d;

        rq1_d = i_wr_ctrl_rptr_gray;
        rq2_d = rq1_q;

        // Gray to binary: each binary bit is the XOR of all Gray bits at or
        // above it.
        rbin = '0;
        for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
            rbin[i] = ^(rq2_q >> i);
        end

        level_d = wbin_d - rbin;
        full_d  = (wgray_d == (rq2_q ^ FULL_MASK));

        // Set has priority over clear.
        ovf_d = (i_wr_ctrl_winc & full_q) | (ovf_q & ~i_wr_ctrl_ovf_clr);

`ifdef UART_FIFO_WR_AFULL_EN
        afull_d = (level_d >= AF_LIMIT);
`endif
    end

    always_ff @(posedge i_mem_ctrl_wclk or negedge i_mem_ctrl_wrst_n) begin
        if (!i_mem_ctrl_wrst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UART_FIFO_WR_AFULL_EN
            afull_q <= 1'b0;
`endif
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= rq1_d;
            rq2_q   <= rq2_d;
            level_q <= level_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
`ifdef UART_FIFO_WR_AFULL_EN
            afull_q <= afull_d;
`endif
        end
    end

    assign o_mem_ctrl_wclk_en  = wclk_en;
    assign o_mem_ctrl_waddr    = wbin_q[PTR_WIDTH-2:0];
    assign o_mem_ctrl_wdata    = i_wr_ctrl_wdata;
    assign o_wr_ctrl_wptr_gray = wgray_q;
    assign o_wr_ctrl_full      = full_q;
    assign o_wr_ctrl_level     = level_q;
    assign o_wr_ctrl_ovf       = ovf_q;
`ifdef UART_FIFO_WR_AFULL_EN
    assign o_wr_ctrl_afull     = afull_q;
`endif

endmodule

// File: tb/tb_uart_fifo_wr_ctrl.sv
// tb_uart_fifo_wr_ctrl
//   Bench for uart_fifo_wr_ctrl with FIFO_DEPTH=8. The read side is modelled
//   as a plain read counter driven as a Gray pointer. The reference model
//   counts accepted writes, delays the read count by two edges and derives
//   occupancy, full, overflow and almost-full from that occupancy.
module tb_uart_fifo_wr_ctrl;

    localparam int DEPTH = 8;
    localparam int PW    = 4;

    logic          clk;
    logic          rst_n;
    logic          winc;
    logic [7:0]    wdata;
    logic          ovf_clr;
    logic [PW-1:0] rptr_gray;
    logic          wclk_en;
    logic [PW-2:0] waddr;
    logic [7:0]    mem_wdata;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic [PW-1:0] level;
    logic          ovf;
`ifdef UART_FIFO_WR_AFULL_EN
    logic          afull;
`endif

    int errors = 0;
    int checks = 0;
    int rd_count = 0;

    // Reference model state (reflects the DUT registers after the last edge).
    int m_wcnt = 0;
    int m_r1 = 0;
    int m_r2 = 0;
    int m_level = 0;
    bit m_full = 0;
    bit m_ovf = 0;
    bit m_afull = 0;
    bit prev_valid = 0;
    logic [PW-1:0] prev_gray = '0;

    uart_fifo_wr_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .AF_THRESH (6)
    ) dut (
        .i_mem_ctrl_wclk    (clk),
        .i_mem_ctrl_wrst_n  (rst_n),
        .i_wr_ctrl_winc     (winc),
        .i_wr_ctrl_wdata    (wdata),
        .i_wr_ctrl_ovf_clr  (ovf_clr),
        .i_wr_ctrl_rptr_gray(rptr_gray),
        .o_mem_ctrl_wclk_en (wclk_en),
        .o_mem_ctrl_waddr   (waddr),
        .o_mem_ctrl_wdata   (mem_wdata),
        .o_wr_ctrl_wptr_gray(wptr_gray),
        .o_wr_ctrl_full     (full),
        .o_wr_ctrl_level    (level),
        .o_wr_ctrl_ovf      (ovf)
`ifdef UART_FIFO_WR_AFULL_EN
        ,
        .o_wr_ctrl_afull    (afull)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [PW-1:0] rb;
        rb = rd_count[PW-1:0];
        rptr_gray = rb ^ (rb >> 1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, then advance the model with the
    // inputs that the coming rising edge will see.
    always @(negedge clk) begin
        logic [PW-1:0] wb;
        int acc;
        int wn;
        if (!rst_n) begin
            m_wcnt = 0; m_r1 = 0; m_r2 = 0; m_level = 0;
            m_full = 0; m_ovf = 0; m_afull = 0; prev_valid = 0;
        end
        wb = m_wcnt[PW-1:0];
        check("waddr",     32'(waddr),     32'(m_wcnt % DEPTH));
        check("wptr_gray", 32'(wptr_gray), 32'(wb ^ (wb >> 1)));
        check("level",     32'(level),     32'(m_level));
        check("full",      32'(full),      32'(m_full));
        check("ovf",       32'(ovf),       32'(m_ovf));
        check("wclk_en",   32'(wclk_en),   32'(winc && !m_full));
        check("mem_wdata", 32'(mem_wdata), 32'(wdata));
`ifdef UART_FIFO_WR_AFULL_EN
        check("afull",     32'(afull),     32'(m_afull));
`endif
        if (rst_n) begin
            if (prev_valid)
                check("gray_step", 32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
            prev_gray  = wptr_gray;
            prev_valid = 1;
            acc     = (winc && !m_full) ? 1 : 0;
            wn      = m_wcnt + acc;
            m_ovf   = (winc && m_full) || (m_ovf && !ovf_clr);
            m_level = ((wn % 16) - m_r2 + 16) % 16;
            m_full  = (m_level == DEPTH);
            m_afull = (m_level >= 6);
            m_r2    = m_r1;
            m_r1    = rd_count % 16;
            m_wcnt  = wn;
        end
    end

    initial begin
        rst_n = 1'b0; winc = 1'b0; wdata = '0; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_full",  32'(full),  32'd0);
        check("rst_gray",  32'(wptr_gray), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;

        // Eight back-to-back writes fill the FIFO.
        for (int i = 0; i < DEPTH; i++) begin
            winc  = 1'b1;
            wdata = 8'($urandom);
            #1;
            check("fill_waddr", 32'(waddr), 32'(i));
            tick();
        end
        check("fill_full",  32'(full),      32'd1);
        check("fill_gray",  32'(wptr_gray), 32'b1100);
        check("fill_level", 32'(level),     32'd8);

        // Writes while full are dropped and flag overflow.
        check("full_en", 32'(wclk_en), 32'd0);
        tick(); tick();
        check("ovf_set",   32'(ovf),   32'd1);
        check("ovf_waddr", 32'(waddr), 32'd0);
        check("ovf_gray",  32'(wptr_gray), 32'b1100);
        winc = 1'b0; ovf_clr = 1'b1;
        tick();
        check("ovf_clr", 32'(ovf), 32'd0);
        winc = 1'b1;
        tick();
        check("ovf_set_wins", 32'(ovf), 32'd1);
        winc = 1'b0;
        tick();
        ovf_clr = 1'b0;

        // One read: full clears on the third edge.
        rd_count = 1;
        tick();
        check("rd_full_e1", 32'(full), 32'd1);
        tick();
        check("rd_full_e2", 32'(full), 32'd1);
        tick();
        check("rd_full_e3",  32'(full),  32'd0);
        check("rd_level_e3", 32'(level), 32'd7);
        winc = 1'b1; wdata = 8'h5a;
        #1;
        check("after_rd_waddr", 32'(waddr),   32'd0);
        check("after_rd_en",    32'(wclk_en), 32'd1);
        tick();

        // Random writes interleaved with reads.
        for (int i = 0; i < 120; i++) begin
            winc    = ($urandom_range(0, 3) != 0);
            wdata   = 8'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0);
            if (rd_count < m_wcnt && $urandom_range(0, 1) == 1) rd_count++;
            tick();
        end
        check("rand_progress", 32'(m_wcnt >= 29), 32'd1);

        // Drain, then build up to level 5 and reset mid-write.
        winc = 1'b0; ovf_clr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rd_count < m_wcnt) rd_count++;
            tick();
        end
        ovf_clr = 1'b0;
        tick(); tick(); tick();
        check("drain_level", 32'(level), 32'd0);
        winc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 8'($urandom);
            tick();
        end
        check("pre_rst_level", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        rd_count = 0;
        #1;
        check("arst_level", 32'(level),     32'd0);
        check("arst_gray",  32'(wptr_gray), 32'd0);
        check("arst_waddr", 32'(waddr),     32'd0);
        check("arst_full",  32'(full),      32'd0);
        check("arst_ovf",   32'(ovf),       32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_waddr", 32'(waddr),   32'd0);
        check("post_rst_en",    32'(wclk_en), 32'd1);
        tick();
        check("post_rst_level", 32'(level),     32'd1);
        check("post_rst_gray",  32'(wptr_gray), 32'd1);

        // Almost-full threshold at 6.
        tick(); tick(); tick(); tick();
        check("lvl5", 32'(level), 32'd5);
`ifdef UART_FIFO_WR_AFULL_EN
        check("afull_at5", 32'(afull), 32'd0);
`endif
        tick();
        winc = 1'b0;
        check("lvl6", 32'(level), 32'd6);
`ifdef UART_FIFO_WR_AFULL_EN
        check("afull_at6", 32'(afull), 32'd1);
`endif
        rd_count = 1;
        tick(); tick(); tick();
        check("lvl_back5", 32'(level), 32'd5);
`ifdef UART_FIFO_WR_AFULL_EN
        check("afull_back5", 32'(afull), 32'd0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
